// File: rtl/pipeline_pkg.sv
// Shared constants and types for the pipeline hazard scoreboard.
// Holds the register index width, decoded-flag bit positions and the
// per-register in-flight counter width.
package pipeline_pkg;

    localparam int REG_ADDR_W       = 5;
    localparam int MAX_INFLIGHT_DEF = 3;

    // Bit positions inside the packed decoded-instruction flag vector
    localparam int FLAG_WR_EN    = 0;
    localparam int FLAG_USES_RS1 = 1;
    localparam int FLAG_USES_RS2 = 2;
    localparam int NUM_FLAGS     = 3;

    // Counter must hold 0..max_inflight inclusive
    function automatic int cnt_width(input int max_inflight);
        return $clog2(max_inflight + 1);
    endfunction

    localparam int CNT_W = cnt_width(MAX_INFLIGHT_DEF);

    // Which output priority is in force this cycle (highest first: ALU_BUSY)
    typedef enum logic [1:0] {
        CTRL_RUN      = 2'd0,
        CTRL_HAZARD   = 2'd1,
        CTRL_FLUSH    = 2'd2,
        CTRL_ALU_BUSY = 2'd3
    } ctrl_mode_e;

endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register in-flight writer counters. Register 0 is never tracked and
// always reads as zero. A simultaneous increment and decrement of the same
// register cancel; decrement at zero and increment at the maximum are ignored.
module hazard_scoreboard
    import pipeline_pkg::*;
#(
    parameter int NUM_REGS     = 32,
    parameter int REG_ADDR_W   = 5,
    parameter int MAX_INFLIGHT = 3,
    parameter int CNT_W        = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inc_en,
    input  logic [REG_ADDR_W-1:0] inc_idx,
    input  logic                  dec_en,
    input  logic [REG_ADDR_W-1:0] dec_idx,
    input  logic [REG_ADDR_W-1:0] rs1_idx,
    input  logic [REG_ADDR_W-1:0] rs2_idx,
    input  logic [REG_ADDR_W-1:0] rd_idx,
    output logic [CNT_W-1:0]      rs1_cnt,
    output logic [CNT_W-1:0]      rs2_cnt,
    output logic [CNT_W-1:0]      rd_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_INFLIGHT);

    logic [CNT_W-1:0]    cnt_q [NUM_REGS];
    logic [NUM_REGS-1:0] inc_hit;
    logic [NUM_REGS-1:0] dec_hit;

    // One-hot decode of the increment / decrement targets, x0 masked out
    always_comb begin
        inc_hit = '0;
        dec_hit = '0;
        if (inc_en && (inc_idx != '0) && (int'(inc_idx) < NUM_REGS)) begin
            inc_hit[inc_idx] = 1'b1;
        end
        if (dec_en && (dec_idx != '0) && (int'(dec_idx) < NUM_REGS)) begin
            dec_hit[dec_idx] = 1'b1;
        end
    end

    // Counter array update; x0 stays zero permanently
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            cnt_q[0] <= '0;
            for (int r = 1; r < NUM_REGS; r++) begin
                if (inc_hit[r] && !dec_hit[r]) begin
                    if (cnt_q[r] != CNT_MAX) begin
                        cnt_q[r] <= cnt_q[r] + 1'b1;
                    end
                end else if (dec_hit[r] && !inc_hit[r]) begin
                    if (cnt_q[r] != '0) begin
                        cnt_q[r] <= cnt_q[r] - 1'b1;
                    end
                end
            end
        end
    end

    // Registered-count read ports for the decoded instruction
    always_comb begin
        rs1_cnt = (int'(rs1_idx) < NUM_REGS) ? cnt_q[rs1_idx] : '0;
        rs2_cnt = (int'(rs2_idx) < NUM_REGS) ? cnt_q[rs2_idx] : '0;
        rd_cnt  = (int'(rd_idx)  < NUM_REGS) ? cnt_q[rd_idx]  : '0;
    end

endmodule

// File: rtl/pipeline_hazard_scoreboard.sv
// Pipeline halt control built on a per-register in-flight writer scoreboard.
// Drives fetch / decode / reg-access / ALU latch enables, inserts bubbles on
// RAW and structural (too many outstanding writers) hazards, stalls the
// whole pipe while the multi-cycle ALU is busy and handles flush.
// Optional stall watchdog is compiled in with HALT_WATCHDOG_EN; without it
// stall_count and timeout_err are tied to zero.
//
// Handshake: an instruction moves from decode into reg_access exactly when
// issue=1 (decoded_valid and no stall/flush/busy); a writer reserves rd on
// that edge and releases it when wb_release=1 with wb_rd=rd.
module pipeline_hazard_scoreboard #(
    parameter int NUM_REGS      = 32,
    parameter int REG_ADDR_W    = pipeline_pkg::REG_ADDR_W,
    parameter int MAX_INFLIGHT  = 3,
    parameter int STALL_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  decoded_valid,
    input  logic [REG_ADDR_W-1:0] decoded_rs1,
    input  logic [REG_ADDR_W-1:0] decoded_rs2,
    input  logic                  decoded_uses_rs1,
    input  logic                  decoded_uses_rs2,
    input  logic [REG_ADDR_W-1:0] decoded_rd,
    input  logic                  decoded_wr_en,
    input  logic                  alu_busy,
    input  logic                  flush,
    input  logic                  wb_release,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    output logic                  fetch_en,
    output logic                  decoded_latch_en,
    output logic                  reg_access_latch_en,
    output logic                  alu_latch_en,
    output logic                  bubble_insert,
    output logic                  issue,
    output logic [7:0]            stall_count,
    output logic                  timeout_err
);

    import pipeline_pkg::*;

    localparam int               CW       = cnt_width(MAX_INFLIGHT);
    localparam logic [CW-1:0]    CNT_FULL = CW'(MAX_INFLIGHT);

    logic [NUM_FLAGS-1:0] dec_flags;
    logic [CW-1:0]        rs1_cnt;
    logic [CW-1:0]        rs2_cnt;
    logic [CW-1:0]        rd_cnt;
    logic                 raw_hazard;
    logic                 struct_hazard;
    logic                 inc_en;
    logic                 dec_en;
    ctrl_mode_e           mode;

    assign dec_flags[FLAG_WR_EN]    = decoded_wr_en;
    assign dec_flags[FLAG_USES_RS1] = decoded_uses_rs1;
    assign dec_flags[FLAG_USES_RS2] = decoded_uses_rs2;

    // Hazard detection from registered counts only
    always_comb begin
        raw_hazard = decoded_valid &
                     ((dec_flags[FLAG_USES_RS1] & (decoded_rs1 != '0) & (rs1_cnt != '0)) |
                      (dec_flags[FLAG_USES_RS2] & (decoded_rs2 != '0) & (rs2_cnt != '0)));
        struct_hazard = decoded_valid & dec_flags[FLAG_WR_EN] &
                        (decoded_rd != '0) & (rd_cnt == CNT_FULL);
    end

    // Output priority selection: ALU busy > flush > hazard > run
    always_comb begin
        mode = CTRL_RUN;
        if (alu_busy) begin
            mode = CTRL_ALU_BUSY;
        end else if (flush) begin
            mode = CTRL_FLUSH;
        end else if (raw_hazard || struct_hazard) begin
            mode = CTRL_HAZARD;
        end
    end

    // Stage enables, bubble and issue; everything low while in reset
    always_comb begin
        fetch_en            = 1'b0;
        decoded_latch_en    = 1'b0;
        reg_access_latch_en = 1'b0;
        alu_latch_en        = 1'b0;
        bubble_insert       = 1'b0;
        issue               = 1'b0;
        if (rst_n) begin
            case (mode)
                CTRL_ALU_BUSY: begin
                end
                CTRL_FLUSH: begin
                    fetch_en            = 1'b1;
                    decoded_latch_en    = 1'b1;
                    reg_access_latch_en = 1'b1;
                    alu_latch_en        = 1'b1;
                    bubble_insert       = 1'b1;
                end
                CTRL_HAZARD: begin
                    reg_access_latch_en = 1'b1;
                    alu_latch_en        = 1'b1;
                    bubble_insert       = 1'b1;
                end
                default: begin
                    fetch_en            = 1'b1;
                    decoded_latch_en    = 1'b1;
                    reg_access_latch_en = 1'b1;
                    alu_latch_en        = 1'b1;
                    issue               = decoded_valid;
                end
            endcase
        end
    end

    assign inc_en = issue & dec_flags[FLAG_WR_EN] & (decoded_rd != '0);
    assign dec_en = wb_release & (wb_rd != '0);

    hazard_scoreboard #(
        .NUM_REGS     (NUM_REGS),
        .REG_ADDR_W   (REG_ADDR_W),
        .MAX_INFLIGHT (MAX_INFLIGHT),
        .CNT_W        (CW)
    ) u_scoreboard (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_en  (inc_en),
        .inc_idx (decoded_rd),
        .dec_en  (dec_en),
        .dec_idx (wb_rd),
        .rs1_idx (decoded_rs1),
        .rs2_idx (decoded_rs2),
        .rd_idx  (decoded_rd),
        .rs1_cnt (rs1_cnt),
        .rs2_cnt (rs2_cnt),
        .rd_cnt  (rd_cnt)
    );

`ifdef HALT_WATCHDOG_EN
    logic [7:0] stall_q;
    logic [7:0] stall_d;
    logic       timeout_q;

    // Consecutive hazard-stall count: grow on hazard, hold on ALU busy, else clear
    always_comb begin
        stall_d = 8'd0;
        case (mode)
            CTRL_HAZARD:   stall_d = (stall_q == 8'hFF) ? stall_q : stall_q + 8'd1;
            CTRL_ALU_BUSY: stall_d = stall_q;
            default:       stall_d = 8'd0;
        endcase
    end

    // Watchdog state; the error is sticky until reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q   <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            stall_q   <= stall_d;
            timeout_q <= timeout_q | (stall_d >= 8'(STALL_TIMEOUT));
        end
    end

    assign stall_count = stall_q;
    assign timeout_err = timeout_q;
`else
    assign stall_count = 8'd0;
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_scoreboard.sv
// Directed bench for pipeline_hazard_scoreboard: producer/consumer RAW stall,
// x0 handling, structural stall at MAX_INFLIGHT, ALU busy, flush and the
// optional watchdog (expectations follow HALT_WATCHDOG_EN).
module tb_pipeline_hazard_scoreboard;

    // Control vector layout: {fetch, dec_le, ra_le, alu_le, bubble, issue}
    localparam logic [5:0] C_ISSUE = 6'b111101;
    localparam logic [5:0] C_IDLE  = 6'b111100;
    localparam logic [5:0] C_HAZ   = 6'b001110;
    localparam logic [5:0] C_FLUSH = 6'b111110;
    localparam logic [5:0] C_BUSY  = 6'b000000;

    logic       clk;
    logic       rst_n;
    logic       decoded_valid;
    logic [4:0] decoded_rs1;
    logic [4:0] decoded_rs2;
    logic       decoded_uses_rs1;
    logic       decoded_uses_rs2;
    logic [4:0] decoded_rd;
    logic       decoded_wr_en;
    logic       alu_busy;
    logic       flush;
    logic       wb_release;
    logic [4:0] wb_rd;
    logic       fetch_en;
    logic       decoded_latch_en;
    logic       reg_access_latch_en;
    logic       alu_latch_en;
    logic       bubble_insert;
    logic       issue;
    logic [7:0] stall_count;
    logic       timeout_err;
    logic [5:0] ctl;

    int n_checks;
    int n_errors;

    assign ctl = {fetch_en, decoded_latch_en, reg_access_latch_en, alu_latch_en,
                  bubble_insert, issue};

    pipeline_hazard_scoreboard #(
        .NUM_REGS      (32),
        .REG_ADDR_W    (5),
        .MAX_INFLIGHT  (3),
        .STALL_TIMEOUT (4)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .decoded_valid       (decoded_valid),
        .decoded_rs1         (decoded_rs1),
        .decoded_rs2         (decoded_rs2),
        .decoded_uses_rs1    (decoded_uses_rs1),
        .decoded_uses_rs2    (decoded_uses_rs2),
        .decoded_rd          (decoded_rd),
        .decoded_wr_en       (decoded_wr_en),
        .alu_busy            (alu_busy),
        .flush               (flush),
        .wb_release          (wb_release),
        .wb_rd               (wb_rd),
        .fetch_en            (fetch_en),
        .decoded_latch_en    (decoded_latch_en),
        .reg_access_latch_en (reg_access_latch_en),
        .alu_latch_en        (alu_latch_en),
        .bubble_insert       (bubble_insert),
        .issue               (issue),
        .stall_count         (stall_count),
        .timeout_err         (timeout_err)
    );

    // Clock: 10 ns period, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog expectations collapse to zero when the feature is not built
    function automatic logic [7:0] wd_cnt(input int v);
`ifdef HALT_WATCHDOG_EN
        return 8'(v);
`else
        return 8'd0 & 8'(v);
`endif
    endfunction

    function automatic logic wd_err(input logic v);
`ifdef HALT_WATCHDOG_EN
        return v;
`else
        return 1'b0 & v;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2,
                         input logic [4:0] rd, input logic wr);
        decoded_valid    = v;
        decoded_rs1      = rs1;
        decoded_uses_rs1 = u1;
        decoded_rs2      = rs2;
        decoded_uses_rs2 = u2;
        decoded_rd       = rd;
        decoded_wr_en    = wr;
    endtask

    task automatic release_wb(input logic en, input logic [4:0] rd);
        wb_release = en;
        wb_rd      = rd;
    endtask

    // Advance to 1 ns after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle before sampling
    task automatic settle();
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        alu_busy = 1'b0;
        flush    = 1'b0;
        release_wb(1'b0, 5'd0);
        drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1);

        // ---- reset state ----
        repeat (2) @(posedge clk);
        #1;
        check("reset_ctl", 32'(ctl), 32'(C_BUSY));
        check("reset_stall", 32'(stall_count), 32'd0);
        check("reset_timeout", 32'(timeout_err), 32'd0);
        rst_n = 1'b1;

        // ---- RAW: producer x5, consumer right behind, release 3 cycles later ----
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
        settle();
        check("raw_producer_issue", 32'(ctl), 32'(C_ISSUE));
        tick();
        drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1);
        settle();
        check("raw_stall1", 32'(ctl), 32'(C_HAZ));
        tick();
        settle();
        check("raw_stall2", 32'(ctl), 32'(C_HAZ));
        tick();
        release_wb(1'b1, 5'd5);
        settle();
        check("raw_stall3_with_release", 32'(ctl), 32'(C_HAZ));
        check("raw_stall_count3", 32'(stall_count), 32'(wd_cnt(2)));
        tick();
        release_wb(1'b0, 5'd0);
        settle();
        check("raw_consumer_issue", 32'(ctl), 32'(C_ISSUE));
        check("raw_stall_count_peak", 32'(stall_count), 32'(wd_cnt(3)));
        tick();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        release_wb(1'b1, 5'd6);
        settle();
        check("raw_idle_after", 32'(ctl), 32'(C_IDLE));
        check("raw_stall_cleared", 32'(stall_count), 32'd0);
        tick();
        release_wb(1'b0, 5'd0);

        // ---- x0 only: never stalls ----
        drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1);
        settle();
        check("x0_first", 32'(ctl), 32'(C_ISSUE));
        tick();
        release_wb(1'b1, 5'd0);
        settle();
        check("x0_second", 32'(ctl), 32'(C_ISSUE));
        tick();
        release_wb(1'b0, 5'd0);
        drive(1'b1, 5'd6, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0);
        settle();
        check("x0_regs_clean", 32'(ctl), 32'(C_ISSUE));
        tick();

        // ---- structural: three writers of x7 in flight, fourth waits ----
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
            settle();
            check($sformatf("struct_writer%0d", i), 32'(ctl), 32'(C_ISSUE));
            tick();
        end
        settle();
        check("struct_fourth_stall", 32'(ctl), 32'(C_HAZ));
        tick();
        release_wb(1'b1, 5'd7);
        settle();
        check("struct_stall_with_release", 32'(ctl), 32'(C_HAZ));
        tick();
        release_wb(1'b0, 5'd0);
        settle();
        check("struct_fourth_issue", 32'(ctl), 32'(C_ISSUE));
        tick();
        drive(1'b1, 5'd7, 1'b0, 5'd7, 1'b0, 5'd0, 1'b0);
        settle();
        check("unused_sources_no_stall", 32'(ctl), 32'(C_ISSUE));
        tick();
        drive(1'b0, 5'd7, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0);
        settle();
        check("invalid_decode_no_stall", 32'(ctl), 32'(C_IDLE));
        for (int i = 0; i < 4; i++) begin
            release_wb(1'b1, 5'd7);
            tick();
        end
        release_wb(1'b0, 5'd0);
        drive(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        settle();
        check("struct_drained", 32'(ctl), 32'(C_ISSUE));
        tick();

        // ---- ALU busy during a RAW hazard ----
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1);
        settle();
        check("busy_producer_issue", 32'(ctl), 32'(C_ISSUE));
        tick();
        drive(1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 5'd10, 1'b1);
        settle();
        check("busy_hazard_before", 32'(ctl), 32'(C_HAZ));
        tick();
        alu_busy = 1'b1;
        settle();
        check("busy_all_off", 32'(ctl), 32'(C_BUSY));
        check("busy_stall_hold", 32'(stall_count), 32'(wd_cnt(1)));
        tick();
        flush = 1'b1;
        settle();
        check("busy_over_flush", 32'(ctl), 32'(C_BUSY));
        tick();
        flush    = 1'b0;
        alu_busy = 1'b0;
        settle();
        check("busy_hazard_resumes", 32'(ctl), 32'(C_HAZ));
        check("busy_stall_resumes", 32'(stall_count), 32'(wd_cnt(1)));
        tick();

        // ---- flush during the hazard stall ----
        flush = 1'b1;
        settle();
        check("flush_ctl", 32'(ctl), 32'(C_FLUSH));
        check("flush_stall_before", 32'(stall_count), 32'(wd_cnt(2)));
        tick();
        flush = 1'b0;
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        release_wb(1'b1, 5'd9);
        settle();
        check("flush_stall_cleared", 32'(stall_count), 32'd0);
        check("flush_idle", 32'(ctl), 32'(C_IDLE));
        tick();
        release_wb(1'b0, 5'd0);
        drive(1'b1, 5'd9, 1'b1, 5'd9, 1'b1, 5'd0, 1'b0);
        settle();
        check("flush_reservation_gone", 32'(ctl), 32'(C_ISSUE));
        tick();

        // ---- watchdog: hazard on x3 held past STALL_TIMEOUT=4 ----
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1);
        settle();
        check("wd_producer_issue", 32'(ctl), 32'(C_ISSUE));
        tick();
        drive(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            settle();
            check($sformatf("wd_stall_count%0d", i), 32'(stall_count), 32'(wd_cnt(i)));
            check($sformatf("wd_timeout%0d", i), 32'(timeout_err), 32'(wd_err(i >= 4)));
            tick();
        end
        release_wb(1'b1, 5'd3);
        tick();
        release_wb(1'b0, 5'd0);
        settle();
        check("wd_consumer_issue", 32'(ctl), 32'(C_ISSUE));
        tick();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1);
        settle();
        check("wd_sticky_stall_zero", 32'(stall_count), 32'd0);
        check("wd_sticky", 32'(timeout_err), 32'(wd_err(1'b1)));
        tick();
        drive(1'b1, 5'd12, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        settle();
        check("pre_reset_x12_hazard", 32'(ctl), 32'(C_HAZ));

        // ---- asynchronous reset mid-cycle discards everything ----
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_ctl", 32'(ctl), 32'(C_BUSY));
        check("async_reset_timeout", 32'(timeout_err), 32'd0);
        check("async_reset_stall", 32'(stall_count), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        settle();
        check("post_reset_x12_free", 32'(ctl), 32'(C_ISSUE));
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
